noip_ctrl_axil_regs: RTL and testbench
======================================

# noip_ctrl_axil_regs

AXI4-Lite responder holding the four 32-bit control registers of the NOIP controller at byte offsets 0x0, 0x4, 0x8 and 0xC. It is the slave end of the AXI4-Lite link driven by the block-design master (VIP in simulation, PS interconnect in hardware). It presents the register contents and per-register write pulses to the NOIP control logic. Software writes values 1..4 to the four offsets and reads the same values back.

## Interface
- ADDR_WIDTH, 4: AXI address width in bits; bits [1:0] are ignored; bits [3:2] select the register; any set bit above [3] is out of range.
- ACLK  in  1  single clock; all logic is on its rising edge
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  accepted and ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  OKAY=2'b00, SLVERR=2'b10
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  accepted and ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data
- ctrl_regs  out  128  register n occupies bits [32n+31:32n]
- ctrl_wr  out  4  one-cycle pulse; bit n is set when register n is written with WSTRB≠0

## Operation
- Write FSM has three states:
  - W_IDLE: AWREADY and WREADY are both 1.
  - W_WAIT: exactly one of AW or W has been latched; the ready for the latched channel drops to 0; the other ready stays 1.
  - W_RESP: BVALID=1 and both readies are 0.
- AW and W may arrive in the same cycle or in either order. Once both are latched, the write commits and the FSM moves to W_RESP.
- W_RESP → W_IDLE on BVALID&&BREADY. BRESP holds stable until the handshake.
- Commit rules:
  - In range: each byte with WSTRB[b]=1 is updated; bytes with WSTRB[b]=0 keep their old value. BRESP=OKAY. ctrl_wr[n] pulses if any strobe bit is set.
  - Out of range: no register changes, BRESP=SLVERR, no pulse.
- Read FSM has two states:
  - R_IDLE: ARREADY=1.
  - R_DATA: ARREADY=0, RVALID=1. RDATA/RRESP are captured at the AR handshake and held until RVALID&&RREADY, then the FSM returns to R_IDLE.
  - Out-of-range read returns RDATA=0 and RRESP=SLVERR.
- Read and write paths are fully independent; one outstanding transaction per direction.
- If a read and a write to the same register hand-shake in the same cycle, the read returns the pre-write value.
- Reset values:
  - all registers are 0, so ctrl_regs=0;
  - ctrl_wr=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0;
  - AWREADY=WREADY=ARREADY=1 in the first cycle after reset deasserts;
  - the FSMs return to W_IDLE and R_IDLE.
- ARESET asserted mid-transaction discards any latched AW/W, pending BVALID and pending RVALID. No response is issued for discarded transactions.

## Timing
- Write with AW and W hand-shaken at edge k:
  - register value visible on ctrl_regs in cycle k+1;
  - ctrl_wr high for cycle k+1 only;
  - BVALID=1 from cycle k+1.
- Split write: latency is counted from the later of the two handshakes.
- Minimum write throughput is one transaction per 2 cycles when BREADY is held at 1.
- Read: AR handshake at edge k gives RVALID=1 from cycle k+1. Minimum throughput is one read per 2 cycles.
- BREADY/RREADY low: VALID and payload are held indefinitely; no new AW/W/AR is accepted on that path.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package noip_ctrl_pkg holds:
  - register offset constants REG_CTRL=0x0, REG_CFG=0x4, REG_ADDR=0x8, REG_DATA=0xC;
  - AXI response codes RESP_OKAY / RESP_SLVERR;
  - the write-FSM and read-FSM state enums.
- Sub-module noip_ctrl_wstrb_merge is combinational: old word, new word and WSTRB in, merged word out. Instantiated once, shared across the four registers.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four back → RDATA 0x1..0x4, all BRESP/RRESP=OKAY, ctrl_wr pulses 0001, 0010, 0100, 1000.
- Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over an old value of 0x00000002 → register reads 0x00BB00DD.
- W asserted 3 cycles before AW (write 0x55 to 0x8) → WREADY drops after the W handshake; commit and BVALID appear one cycle after the AW handshake; register = 0x55.
- BREADY held low for 10 cycles → BVALID and BRESP are stable, AWREADY and WREADY stay 0, and a second write is accepted only after the B handshake.
- With ADDR_WIDTH=8: write to 0x10 → BRESP=SLVERR, registers unchanged; read from 0x10 → RDATA=0, RRESP=SLVERR.
- ARESET pulsed while RVALID is pending and while W is latched → RVALID and BVALID go to 0, ctrl_regs=0, and a following write/read to 0x0 completes normally.

Source files
------------

// File: rtl/noip_ctrl_pkg.sv
// Shared definitions for the NOIP controller register block:
// register offsets, AXI response codes and FSM state types.
package noip_ctrl_pkg;

    localparam logic [3:0] REG_CTRL = 4'h0;
    localparam logic [3:0] REG_CFG  = 4'h4;
    localparam logic [3:0] REG_ADDR = 4'h8;
    localparam logic [3:0] REG_DATA = 4'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/noip_ctrl_axil_regs_if.sv
// AXI4-Lite link between the block-design master and the NOIP control registers.
interface noip_ctrl_axil_regs_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/noip_ctrl_wstrb_merge.sv
// Byte-lane merge of a new write word into an old register word under WSTRB.
module noip_ctrl_wstrb_merge
    import noip_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  strb,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
    end

endmodule

// File: rtl/noip_ctrl_axil_regs.sv
// AXI4-Lite responder for the four NOIP control registers, with per-register
// write pulses toward the controller logic.
module noip_ctrl_axil_regs
    import noip_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    noip_ctrl_axil_regs_if.slave s_axi,
    output logic [127:0]         ctrl_regs,
    output logic [3:0]           ctrl_wr
);

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic [31:0]           regs [4];
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;

    logic                  aw_hs, w_hs, ar_hs, have_aw, have_w, commit;
    logic [ADDR_WIDTH-1:0] aw_sel;
    logic [31:0]           wdata_sel, merged;
    logic [3:0]            wstrb_sel;
    logic [1:0]            w_idx, r_idx;
    logic                  w_ok, r_ok;
    logic                  unused_bits;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> 4) == '0;
    endfunction

    assign aw_hs = s_axi.awvalid && awready_q;
    assign w_hs  = s_axi.wvalid && wready_q;
    assign ar_hs = s_axi.arvalid && arready_q;

    // A channel arriving this cycle bypasses its holding register so that a
    // write can commit on the same edge as its later handshake.
    assign have_aw   = aw_held_q || aw_hs;
    assign have_w    = w_held_q || w_hs;
    assign aw_sel    = aw_hs ? s_axi.awaddr : awaddr_q;
    assign wdata_sel = w_hs ? s_axi.wdata : wdata_q;
    assign wstrb_sel = w_hs ? s_axi.wstrb : wstrb_q;
    assign w_idx     = aw_sel[3:2];
    assign w_ok      = in_range(aw_sel);
    assign r_idx     = s_axi.araddr[3:2];
    assign r_ok      = in_range(s_axi.araddr);

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, aw_sel[1:0], s_axi.araddr[1:0]};

    noip_ctrl_wstrb_merge u_merge (
        .old_word (regs[w_idx]),
        .new_word (wdata_sel),
        .strb     (wstrb_sel),
        .merged   (merged)
    );

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE, W_WAIT: begin
                if (have_aw && have_w) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else if (aw_hs || w_hs) begin
                    w_state_d = W_WAIT;
                    aw_held_d = have_aw;
                    w_held_d  = have_w;
                end
            end
            W_RESP: if (s_axi.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (s_axi.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ctrl_wr   <= '0;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_WAIT && !aw_held_d);
            wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_WAIT && !w_held_d);
            bvalid_q  <= (w_state_d == W_RESP);
            ctrl_wr   <= '0;
            if (aw_hs) awaddr_q <= s_axi.awaddr;
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
            if (commit) begin
                if (w_ok) begin
                    regs[w_idx]    <= merged;
                    ctrl_wr[w_idx] <= |wstrb_sel;
                    bresp_q        <= RESP_OKAY;
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
            if (ar_hs) begin
                rdata_q <= r_ok ? regs[r_idx] : '0;
                rresp_q <= r_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        ctrl_regs = '0;
        for (int unsigned i = 0; i < 4; i++) ctrl_regs[32*i +: 32] = regs[i];
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_noip_ctrl_axil_regs.sv
// Bench for noip_ctrl_axil_regs: directed scenarios plus randomized traffic
// checked against a word-array model of the four registers.
module tb_noip_ctrl_axil_regs;
    import noip_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         arst;
    logic [127:0] ctrl_regs;
    logic [3:0]   ctrl_wr;
    int           checks = 0;
    int           failures = 0;
    logic [31:0]  model [4];

    noip_ctrl_axil_regs_if #(.ADDR_WIDTH(8)) axi ();

    noip_ctrl_axil_regs #(.ADDR_WIDTH(8)) dut (
        .ACLK      (clk),
        .ARESET    (arst),
        .s_axi     (axi),
        .ctrl_regs (ctrl_regs),
        .ctrl_wr   (ctrl_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] exp_regs();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Advances edge by edge until every requested ready is seen high; returns #1 after that edge.
    task automatic wait_hs(input string name, input bit need_aw, input bit need_w, input bit need_ar);
        bit hs = 1'b0;
        for (int n = 0; n < 50 && !hs; n++) begin
            hs = (!need_aw || axi.awready) && (!need_w || axi.wready) && (!need_ar || axi.arready);
            @(posedge clk); #1;
        end
        if (!hs) begin
            checks++; failures++;
            $display("FAIL %s: handshake timeout", name);
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] pulse);
        axi.awaddr = addr; axi.awprot = 3'($urandom); axi.awvalid = 1'b1;
        axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1; axi.bready = 1'b0;
        wait_hs("write_hs", 1'b1, 1'b1, 1'b0);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        checks++;
        if (axi.bvalid !== 1'b1) begin
            failures++; $display("FAIL write_bvalid: got %b want 1", axi.bvalid);
        end
        resp = axi.bresp; pulse = ctrl_wr;
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        checks++;
        if (axi.bvalid !== 1'b0 || ctrl_wr !== 4'b0000) begin
            failures++; $display("FAIL write_done: bvalid=%b ctrl_wr=%b want 0/0000", axi.bvalid, ctrl_wr);
        end
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        axi.araddr = addr; axi.arprot = 3'($urandom); axi.arvalid = 1'b1; axi.rready = 1'b0;
        wait_hs("read_hs", 1'b0, 1'b0, 1'b1);
        axi.arvalid = 1'b0;
        checks++;
        if (axi.rvalid !== 1'b1) begin
            failures++; $display("FAIL read_rvalid: got %b want 1", axi.rvalid);
        end
        data = axi.rdata; resp = axi.rresp;
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
        checks++;
        if (axi.rvalid !== 1'b0) begin
            failures++; $display("FAIL read_done: rvalid=%b want 0", axi.rvalid);
        end
    endtask

    // Predicts and checks one write against the model.
    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] resp, exp_resp;
        logic [3:0] pulse, exp_pulse;
        int idx;
        idx = (int'(addr) % 16) / 4;
        bus_write(addr, data, strb, resp, pulse);
        if (addr < 8'd16) begin
            model[idx] = apply_strb(model[idx], data, strb);
            exp_resp = RESP_OKAY;
            exp_pulse = (strb != 4'b0) ? 4'(1 << idx) : 4'b0;
        end else begin
            exp_resp = RESP_SLVERR;
            exp_pulse = 4'b0;
        end
        checks++;
        if (resp !== exp_resp || pulse !== exp_pulse || ctrl_regs !== exp_regs()) begin
            failures++;
            $display("FAIL write @%h: bresp=%b ctrl_wr=%b regs=%h want %b/%b/%h",
                     addr, resp, pulse, ctrl_regs, exp_resp, exp_pulse, exp_regs());
        end
    endtask

    task automatic model_read(input logic [7:0] addr);
        logic [31:0] data, exp_data;
        logic [1:0]  resp, exp_resp;
        bus_read(addr, data, resp);
        exp_data = (addr < 8'd16) ? model[(int'(addr) % 16) / 4] : 32'h0;
        exp_resp = (addr < 8'd16) ? RESP_OKAY : RESP_SLVERR;
        checks++;
        if (data !== exp_data || resp !== exp_resp) begin
            failures++;
            $display("FAIL read @%h: rdata=%h rresp=%b want %h/%b", addr, data, resp, exp_data, exp_resp);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ctrl_regs !== '0 || ctrl_wr !== 4'b0 || axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0 ||
            axi.bresp !== 2'b0 || axi.rresp !== 2'b0 || axi.rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: regs=%h wr=%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h want all 0",
                     ctrl_regs, ctrl_wr, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata);
        end
        checks++;
        if (axi.awready !== 1'b1 || axi.wready !== 1'b1 || axi.arready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: aw=%b w=%b ar=%b want 111", axi.awready, axi.wready, axi.arready);
        end
    endtask

    task automatic test_basic();
        model_write({4'h0, REG_CTRL}, 32'h1, 4'hF);
        model_write({4'h0, REG_CFG},  32'h2, 4'hF);
        model_write({4'h0, REG_ADDR}, 32'h3, 4'hF);
        model_write({4'h0, REG_DATA}, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) model_read(8'(4 * i));
    endtask

    task automatic test_strobe();
        model_write({4'h0, REG_CFG}, 32'hAABBCCDD, 4'b0101);
        checks++;
        if (model[1] !== 32'h00BB00DD || ctrl_regs[63:32] !== 32'h00BB00DD) begin
            failures++; $display("FAIL strobe_merge: got %h want 00bb00dd", ctrl_regs[63:32]);
        end
        model_read({4'h0, REG_CFG});
        model_write({4'h0, REG_CFG}, 32'hFFFFFFFF, 4'b0000);
    endtask

    task automatic test_w_before_aw();
        axi.wdata = 32'h55; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        wait_hs("w_first_hs", 1'b0, 1'b1, 1'b0);
        axi.wvalid = 1'b0;
        checks++;
        if (axi.wready !== 1'b0 || axi.awready !== 1'b1 || axi.bvalid !== 1'b0) begin
            failures++;
            $display("FAIL w_latched: wready=%b awready=%b bvalid=%b want 0/1/0", axi.wready, axi.awready, axi.bvalid);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (axi.bvalid !== 1'b0 || ctrl_regs !== exp_regs()) begin
            failures++; $display("FAIL w_wait_idle: bvalid=%b regs=%h want 0/%h", axi.bvalid, ctrl_regs, exp_regs());
        end
        axi.awaddr = {4'h0, REG_ADDR}; axi.awvalid = 1'b1;
        wait_hs("aw_late_hs", 1'b1, 1'b0, 1'b0);
        axi.awvalid = 1'b0;
        model[2] = 32'h55;
        checks++;
        if (axi.bvalid !== 1'b1 || ctrl_wr !== 4'b0100 || ctrl_regs !== exp_regs()) begin
            failures++;
            $display("FAIL split_commit: bvalid=%b wr=%b regs=%h want 1/0100/%h", axi.bvalid, ctrl_wr, ctrl_regs, exp_regs());
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic test_bready_stall();
        logic [31:0] d1, d2;
        int bad = 0;
        d1 = $urandom; d2 = $urandom;
        axi.awaddr = {4'h0, REG_DATA}; axi.wdata = d1; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
        wait_hs("stall_first_hs", 1'b1, 1'b1, 1'b0);
        model[3] = d1;
        axi.awaddr = {4'h0, REG_CTRL}; axi.wdata = d2;
        for (int c = 0; c < 10; c++) begin
            if (axi.bvalid !== 1'b1 || axi.bresp !== RESP_OKAY || axi.awready !== 1'b0 ||
                axi.wready !== 1'b0 || ctrl_regs !== exp_regs()) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bready_stall: %0d unstable cycles, want 0", bad);
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (axi.bvalid !== 1'b0 || axi.awready !== 1'b1 || axi.wready !== 1'b1 || ctrl_regs !== exp_regs()) begin
            failures++;
            $display("FAIL stall_release: bvalid=%b aw=%b w=%b regs=%h want 0/1/1/%h",
                     axi.bvalid, axi.awready, axi.wready, ctrl_regs, exp_regs());
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        model[0] = d2;
        checks++;
        if (axi.bvalid !== 1'b1 || ctrl_regs !== exp_regs()) begin
            failures++; $display("FAIL second_write: bvalid=%b regs=%h want 1/%h", axi.bvalid, ctrl_regs, exp_regs());
        end
        @(posedge clk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic test_out_of_range();
        model_write(8'h10, $urandom, 4'hF);
        model_write(8'h83, $urandom, 4'hF);
        model_read(8'h10);
        model_read(8'hFC);
    endtask

    task automatic test_same_cycle();
        logic [31:0] old_w, new_w;
        int idx;
        idx = int'($urandom_range(0, 3));
        new_w = $urandom;
        old_w = model[idx];
        axi.awaddr = 8'(4 * idx); axi.wdata = new_w; axi.wstrb = 4'hF;
        axi.araddr = 8'(4 * idx);
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        wait_hs("same_cycle_hs", 1'b1, 1'b1, 1'b1);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        model[idx] = new_w;
        checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== old_w || axi.bvalid !== 1'b1 || ctrl_regs !== exp_regs()) begin
            failures++;
            $display("FAIL same_cycle: rv=%b rdata=%h bv=%b regs=%h want 1/%h/1/%h",
                     axi.rvalid, axi.rdata, axi.bvalid, ctrl_regs, old_w, exp_regs());
        end
        axi.bready = 1'b1; axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0; axi.rready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0)
                model_write(8'($urandom_range(0, 31)), $urandom, 4'($urandom));
            else
                model_read(8'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        d = $urandom;
        axi.araddr = {4'h0, REG_CFG}; axi.arvalid = 1'b1; axi.rready = 1'b0;
        wait_hs("mid_ar_hs", 1'b0, 1'b0, 1'b1);
        axi.arvalid = 1'b0;
        axi.wdata = $urandom; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        wait_hs("mid_w_hs", 1'b0, 1'b1, 1'b0);
        axi.wvalid = 1'b0;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        checks++;
        if (axi.rvalid !== 1'b0 || axi.bvalid !== 1'b0 || ctrl_regs !== '0 ||
            axi.awready !== 1'b1 || axi.wready !== 1'b1 || axi.arready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: rv=%b bv=%b regs=%h aw=%b w=%b ar=%b want 0/0/0/1/1/1",
                     axi.rvalid, axi.bvalid, ctrl_regs, axi.awready, axi.wready, axi.arready);
        end
        axi.awaddr = {4'h0, REG_CTRL}; axi.awvalid = 1'b1;
        wait_hs("post_reset_aw", 1'b1, 1'b0, 1'b0);
        axi.awvalid = 1'b0;
        checks++;
        if (axi.bvalid !== 1'b0 || ctrl_regs !== '0) begin
            failures++; $display("FAIL discarded_w: bvalid=%b regs=%h want 0/0", axi.bvalid, ctrl_regs);
        end
        axi.wdata = d; axi.wvalid = 1'b1;
        wait_hs("post_reset_w", 1'b0, 1'b1, 1'b0);
        axi.wvalid = 1'b0;
        model[0] = d;
        checks++;
        if (axi.bvalid !== 1'b1 || ctrl_regs !== exp_regs()) begin
            failures++; $display("FAIL post_reset_write: bvalid=%b regs=%h want 1/%h", axi.bvalid, ctrl_regs, exp_regs());
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        model_read({4'h0, REG_CTRL});
    endtask

    initial begin
        arst = 1'b1;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_bready_stall();
        test_out_of_range();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
